// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit and its decoder.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_RETIRE
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_JUMP1,
        CL_JUMP2,
        CL_BZ,
        CL_BNZ,
        CL_ILLEGAL
    } class_t;

    localparam logic [4:0] OPC_LOAD  = 5'b11111;
    localparam logic [4:0] OPC_STORE = 5'b00000;
    localparam logic [4:0] OPC_JUMP1 = 5'b11001;
    localparam logic [4:0] OPC_JUMP2 = 5'b11010;
    localparam logic [4:0] OPC_BZ    = 5'b11011;
    localparam logic [4:0] OPC_BNZ   = 5'b11100;

    localparam logic [2:0] PC_NEXT      = 3'b000;
    localparam logic [2:0] PC_JUMP1     = 3'b001;
    localparam logic [2:0] PC_JUMP2     = 3'b010;
    localparam logic [2:0] PC_BZ_TAKEN  = 3'b011;
    localparam logic [2:0] PC_BNZ_TAKEN = 3'b100;

    localparam logic [4:0] ALU_OP_SUB = 5'b00001;

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational instruction classifier: splits a fetched word into class and operand fields.
module instr_decoder
    import cu_pkg::*;
#(
    parameter int DMEM_AW = 16,
    parameter bit BNZ_EN  = 1'b0
) (
    input  logic [31:0]        instr,
    output logic [2:0]         cls,
    output logic [4:0]         op,
    output logic [4:0]         wadd,
    output logic [4:0]         radd0,
    output logic [4:0]         radd1,
    output logic               cin,
    output logic [DMEM_AW-1:0] mem_addr
);

    logic unused_bits;
    assign unused_bits = ^instr;

    always_comb begin
        cls      = CL_ILLEGAL;
        op       = instr[30:26];
        wadd     = 5'd0;
        radd0    = 5'd0;
        radd1    = 5'd0;
        cin      = 1'b0;
        mem_addr = instr[DMEM_AW+1:2];
        if (!instr[31]) begin
            cls   = CL_ALU;
            wadd  = instr[25:21];
            radd0 = instr[20:16];
            radd1 = instr[15:11];
            cin   = instr[10];
        end else begin
            case (instr[30:26])
                OPC_LOAD: begin
                    cls  = CL_LOAD;
                    wadd = instr[25:21];
                end
                OPC_STORE: begin
                    cls   = CL_STORE;
                    radd0 = instr[20:16];
                end
                OPC_JUMP1: cls = CL_JUMP1;
                OPC_JUMP2: cls = CL_JUMP2;
                OPC_BZ: begin
                    cls   = CL_BZ;
                    radd0 = instr[20:16];
                    radd1 = instr[15:11];
                end
                OPC_BNZ: begin
                    // Opcode is only recognised when the branch option is built in.
                    if (BNZ_EN) begin
                        cls   = CL_BNZ;
                        radd0 = instr[20:16];
                        radd1 = instr[15:11];
                    end
                end
                default: cls = CL_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Five-state multicycle sequencer: fetch handshake, decode, ALU/branch execute, data-memory access, retire.
// state     | meaning
// FETCH     | ready for an instruction, idle
// DECODE    | register addresses driven
// EXEC      | ALU enabled, branch zero flag sampled
// MEM       | memory enable held until ack or timeout
// RETIRE    | PC strobe and optional register write
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int DMEM_AW     = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter bit BNZ_EN      = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               alu_zero,
    input  logic               dmem_ack,
    output logic [4:0]         reg_radd0,
    output logic [4:0]         reg_radd1,
    output logic [4:0]         reg_wadd,
    output logic               reg_file_write_en,
    output logic               reg_wsel,
    output logic [4:0]         alu_opcode,
    output logic               alu_cin,
    output logic               alu_en,
    output logic [DMEM_AW-1:0] data_mem_add,
    output logic               data_mem_read_en,
    output logic               data_mem_write_en,
    output logic [2:0]         pc_control,
    output logic               pc_en,
    output logic               illegal,
    output logic               busy
);

    localparam logic [7:0] CNT_INIT = 8'(MEM_TIMEOUT - 1);

    logic [2:0]         dec_cls;
    logic [4:0]         dec_op, dec_wadd, dec_radd0, dec_radd1;
    logic               dec_cin;
    logic [DMEM_AW-1:0] dec_addr;
    class_t             dec_class;

    instr_decoder #(.DMEM_AW(DMEM_AW), .BNZ_EN(BNZ_EN)) u_dec (
        .instr    (instr),
        .cls      (dec_cls),
        .op       (dec_op),
        .wadd     (dec_wadd),
        .radd0    (dec_radd0),
        .radd1    (dec_radd1),
        .cin      (dec_cin),
        .mem_addr (dec_addr)
    );
    assign dec_class = class_t'(dec_cls);

    state_t             state_q, state_d;
    class_t             cls_q, cls_d;
    logic [4:0]         op_q, op_d;
    logic               cin_q, cin_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4:0]         radd0_q, radd0_d, radd1_q, radd1_d, wadd_q, wadd_d;
    logic               reg_we_q, reg_we_d, reg_wsel_q, reg_wsel_d;
    logic [4:0]         alu_opcode_q, alu_opcode_d;
    logic               alu_cin_q, alu_cin_d, alu_en_q, alu_en_d;
    logic [DMEM_AW-1:0] dmem_add_q, dmem_add_d;
    logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [2:0]         pc_control_q, pc_control_d;
    logic               pc_en_q, pc_en_d, illegal_q, illegal_d;
    logic               busy_q, busy_d, instr_ready_q, instr_ready_d;

    // Outputs are computed for the state being entered, so every output is a flop.
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        op_d          = op_q;
        cin_d         = cin_q;
        cnt_d         = cnt_q;
        radd0_d       = radd0_q;
        radd1_d       = radd1_q;
        wadd_d        = wadd_q;
        dmem_add_d    = dmem_add_q;
        illegal_d     = illegal_q;
        instr_ready_d = 1'b0;
        busy_d        = 1'b1;
        alu_en_d      = 1'b0;
        alu_opcode_d  = 5'd0;
        alu_cin_d     = 1'b0;
        rd_en_d       = 1'b0;
        wr_en_d       = 1'b0;
        pc_en_d       = 1'b0;
        pc_control_d  = PC_NEXT;
        reg_we_d      = 1'b0;
        reg_wsel_d    = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (instr_valid && instr_ready_q) begin
                    state_d = ST_DECODE;
                    cls_d   = dec_class;
                    op_d    = dec_op;
                    cin_d   = dec_cin;
                    radd0_d = dec_radd0;
                    radd1_d = dec_radd1;
                    wadd_d  = dec_wadd;
                    if (dec_class == CL_LOAD || dec_class == CL_STORE) dmem_add_d = dec_addr;
                end else begin
                    instr_ready_d = 1'b1;
                    busy_d        = 1'b0;
                end
            end
            ST_DECODE: begin
                case (cls_q)
                    CL_ALU, CL_BZ, CL_BNZ: begin
                        state_d      = ST_EXEC;
                        alu_en_d     = 1'b1;
                        alu_opcode_d = (cls_q == CL_ALU) ? op_q : ALU_OP_SUB;
                        alu_cin_d    = (cls_q == CL_ALU) && cin_q;
                    end
                    CL_LOAD, CL_STORE: begin
                        state_d = ST_MEM;
                        cnt_d   = CNT_INIT;
                        rd_en_d = (cls_q == CL_LOAD);
                        wr_en_d = (cls_q == CL_STORE);
                    end
                    default: begin
                        state_d      = ST_RETIRE;
                        pc_en_d      = 1'b1;
                        pc_control_d = (cls_q == CL_JUMP1) ? PC_JUMP1 :
                                       (cls_q == CL_JUMP2) ? PC_JUMP2 : PC_NEXT;
                        illegal_d    = illegal_q || (cls_q == CL_ILLEGAL);
                    end
                endcase
            end
            ST_EXEC: begin
                state_d  = ST_RETIRE;
                pc_en_d  = 1'b1;
                reg_we_d = (cls_q == CL_ALU);
                if (cls_q == CL_BZ && alu_zero)        pc_control_d = PC_BZ_TAKEN;
                else if (cls_q == CL_BNZ && !alu_zero) pc_control_d = PC_BNZ_TAKEN;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d    = ST_RETIRE;
                    pc_en_d    = 1'b1;
                    reg_we_d   = (cls_q == CL_LOAD);
                    reg_wsel_d = (cls_q == CL_LOAD);
                end else if (cnt_q == 8'd0) begin
                    // Memory never answered: abandon the access and flag it.
                    state_d   = ST_RETIRE;
                    pc_en_d   = 1'b1;
                    illegal_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    rd_en_d = rd_en_q;
                    wr_en_d = wr_en_q;
                end
            end
            ST_RETIRE: begin
                state_d       = ST_FETCH;
                instr_ready_d = 1'b1;
                busy_d        = 1'b0;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            cls_q         <= CL_ALU;
            op_q          <= 5'd0;
            cin_q         <= 1'b0;
            cnt_q         <= 8'd0;
            radd0_q       <= 5'd0;
            radd1_q       <= 5'd0;
            wadd_q        <= 5'd0;
            reg_we_q      <= 1'b0;
            reg_wsel_q    <= 1'b0;
            alu_opcode_q  <= 5'd0;
            alu_cin_q     <= 1'b0;
            alu_en_q      <= 1'b0;
            dmem_add_q    <= '0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            pc_control_q  <= PC_NEXT;
            pc_en_q       <= 1'b0;
            illegal_q     <= 1'b0;
            busy_q        <= 1'b0;
            instr_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            op_q          <= op_d;
            cin_q         <= cin_d;
            cnt_q         <= cnt_d;
            radd0_q       <= radd0_d;
            radd1_q       <= radd1_d;
            wadd_q        <= wadd_d;
            reg_we_q      <= reg_we_d;
            reg_wsel_q    <= reg_wsel_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_cin_q     <= alu_cin_d;
            alu_en_q      <= alu_en_d;
            dmem_add_q    <= dmem_add_d;
            rd_en_q       <= rd_en_d;
            wr_en_q       <= wr_en_d;
            pc_control_q  <= pc_control_d;
            pc_en_q       <= pc_en_d;
            illegal_q     <= illegal_d;
            busy_q        <= busy_d;
            instr_ready_q <= instr_ready_d;
        end
    end

    assign instr_ready       = instr_ready_q;
    assign reg_radd0         = radd0_q;
    assign reg_radd1         = radd1_q;
    assign reg_wadd          = wadd_q;
    assign reg_file_write_en = reg_we_q;
    assign reg_wsel          = reg_wsel_q;
    assign alu_opcode        = alu_opcode_q;
    assign alu_cin           = alu_cin_q;
    assign alu_en            = alu_en_q;
    assign data_mem_add      = dmem_add_q;
    assign data_mem_read_en  = rd_en_q;
    assign data_mem_write_en = wr_en_q;
    assign pc_control        = pc_control_q;
    assign pc_en             = pc_en_q;
    assign illegal           = illegal_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for the multicycle control unit: two builds (default, and narrow/short-timeout/BNZ) against a transaction-level model.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic [31:0] instr[2];
    logic        ivalid[2], azero[2], dack[2];
    logic        iready[2], rwe[2], wsel[2], acin[2], aen[2], rd[2], wr[2], pcen[2], ill[2], busy[2];
    logic [4:0]  radd0[2], radd1[2], wadd[2], aop[2];
    logic [2:0]  pcc[2];
    logic [15:0] dm0;
    logic [7:0]  dm1;

    multicycle_control_unit dut0 (
        .clk(clk), .rst(rst[0]), .instr(instr[0]), .instr_valid(ivalid[0]), .instr_ready(iready[0]),
        .alu_zero(azero[0]), .dmem_ack(dack[0]), .reg_radd0(radd0[0]), .reg_radd1(radd1[0]),
        .reg_wadd(wadd[0]), .reg_file_write_en(rwe[0]), .reg_wsel(wsel[0]), .alu_opcode(aop[0]),
        .alu_cin(acin[0]), .alu_en(aen[0]), .data_mem_add(dm0), .data_mem_read_en(rd[0]),
        .data_mem_write_en(wr[0]), .pc_control(pcc[0]), .pc_en(pcen[0]), .illegal(ill[0]), .busy(busy[0])
    );

    multicycle_control_unit #(.DMEM_AW(8), .MEM_TIMEOUT(4), .BNZ_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst[1]), .instr(instr[1]), .instr_valid(ivalid[1]), .instr_ready(iready[1]),
        .alu_zero(azero[1]), .dmem_ack(dack[1]), .reg_radd0(radd0[1]), .reg_radd1(radd1[1]),
        .reg_wadd(wadd[1]), .reg_file_write_en(rwe[1]), .reg_wsel(wsel[1]), .alu_opcode(aop[1]),
        .alu_cin(acin[1]), .alu_en(aen[1]), .data_mem_add(dm1), .data_mem_read_en(rd[1]),
        .data_mem_write_en(wr[1]), .pc_control(pcc[1]), .pc_en(pcen[1]), .illegal(ill[1]), .busy(busy[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    bit m_ill[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int timeout_of(input int d);
        return (d == 0) ? 15 : 4;
    endfunction

    function automatic int aw_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic logic [31:0] dmadd_of(input int d);
        return (d == 0) ? {16'h0, dm0} : {24'h0, dm1};
    endfunction

    function automatic logic [31:0] all_outs(input int d);
        return {radd0[d], radd1[d], wadd[d], rwe[d], wsel[d], aop[d], acin[d], aen[d],
                rd[d], wr[d], pcc[d], pcen[d], ill[d], busy[d]};
    endfunction

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        @(negedge clk);
        chk("reset_outs", all_outs(d), 32'h0);
        chk("reset_dmadd", dmadd_of(d), 32'h0);
        chk("reset_ready", iready[d], 1);
        rst[d] = 1'b0;
        m_ill[d] = 1'b0;
    endtask

    // ack_at: MEM cycle (1-based) in which dmem_ack is raised; 0 or beyond the timeout means never.
    task automatic run_txn(input int d, input logic [31:0] ins, input int ack_at, input bit zero);
        logic [4:0] f;
        bit alu, ld, st, j1, j2, bz, bnz, illeg, mem, exec_c, acked, exp_we;
        int memc, lat, k, nrd, nwr, nwe, ret_k;
        logic [2:0] exp_pc;
        logic [31:0] mask;
        f      = ins[30:26];
        alu    = !ins[31];
        ld     = ins[31] && f == 5'd31;
        st     = ins[31] && f == 5'd0;
        j1     = ins[31] && f == 5'd25;
        j2     = ins[31] && f == 5'd26;
        bz     = ins[31] && f == 5'd27;
        bnz    = ins[31] && f == 5'd28 && d == 1;
        illeg  = !(alu || ld || st || j1 || j2 || bz || bnz);
        mem    = ld || st;
        exec_c = alu || bz || bnz;
        memc   = 0;
        acked  = 1'b0;
        if (mem) begin
            if (ack_at >= 1 && ack_at <= timeout_of(d)) begin
                memc  = ack_at;
                acked = 1'b1;
            end else begin
                memc = timeout_of(d);
            end
        end
        lat    = exec_c ? 3 : (mem ? 2 + memc : 2);
        exp_pc = j1 ? 3'd1 : j2 ? 3'd2 : (bz && zero) ? 3'd3 : (bnz && !zero) ? 3'd4 : 3'd0;
        exp_we = alu || (ld && acked);
        m_ill[d] = m_ill[d] || illeg || (mem && !acked);
        mask   = (32'h1 << aw_of(d)) - 32'h1;

        @(negedge clk);
        chk("fetch_ready", iready[d], 1);
        chk("fetch_busy", busy[d], 0);
        instr[d]  = ins;
        ivalid[d] = 1'b1;
        dack[d]   = 1'($urandom);
        azero[d]  = 1'($urandom);
        @(negedge clk);
        ivalid[d] = 1'b0;
        instr[d]  = $urandom;
        nrd = 0; nwr = 0; nwe = 0; ret_k = 0;
        for (k = 1; k <= 60; k++) begin
            nrd += int'(rd[d]);
            nwr += int'(wr[d]);
            nwe += int'(rwe[d]);
            if (k == 1) begin
                chk("dec_busy", busy[d], 1);
                chk("dec_ready", iready[d], 0);
                if (alu) begin
                    chk("dec_radd0", radd0[d], ins[20:16]);
                    chk("dec_radd1", radd1[d], ins[15:11]);
                end
                if (st) chk("dec_radd0_st", radd0[d], ins[20:16]);
            end
            if (k == 2 && exec_c) begin
                chk("exec_alu_en", aen[d], 1);
                chk("exec_opcode", aop[d], alu ? f : 5'd1);
                chk("exec_cin", acin[d], alu ? ins[10] : 1'b0);
            end
            if (k == 2 && mem) chk("mem_addr", dmadd_of(d), (ins >> 2) & mask);
            if (pcen[d]) begin
                ret_k = k;
                break;
            end
            if (mem && k >= 2 && k <= 1 + memc) dack[d] = (k == ack_at + 1);
            else dack[d] = 1'($urandom);
            azero[d] = (exec_c && k == 2) ? zero : 1'($urandom);
            @(negedge clk);
        end
        if (ret_k == 0) begin
            chk("retire_seen", 0, 1);
        end else begin
            chk("latency", ret_k, lat);
            chk("ret_we", rwe[d], exp_we);
            if (exp_we) begin
                chk("ret_wsel", wsel[d], ld);
                chk("ret_wadd", wadd[d], ins[25:21]);
            end
            chk("ret_pc_control", pcc[d], exp_pc);
            chk("ret_busy", busy[d], 1);
            chk("illegal", ill[d], m_ill[d]);
            chk("rd_cycles", nrd, ld ? memc : 0);
            chk("wr_cycles", nwr, st ? memc : 0);
            chk("we_pulses", nwe, exp_we);
        end
        dack[d]  = 1'b0;
        azero[d] = 1'b0;
        @(negedge clk);
        chk("post_ready", iready[d], 1);
        chk("post_pc_en", pcen[d], 0);
        chk("post_we", rwe[d], 0);
    endtask

    task automatic rand_instr(output logic [31:0] ins);
        logic [31:0] r;
        logic [4:0] opcs[7];
        int sel;
        opcs = '{5'd31, 5'd0, 5'd25, 5'd26, 5'd27, 5'd28, 5'd0};
        r   = $urandom;
        sel = $urandom_range(0, 8);
        if (sel == 0 || sel == 1)      ins = {1'b0, r[30:0]};
        else if (sel == 8)             ins = {1'b1, 5'(r[30:26]), r[25:0]};
        else begin
            opcs[6] = 5'($urandom_range(1, 24));
            ins = {1'b1, opcs[sel - 2], r[25:0]};
        end
    endtask

    initial begin
        logic [31:0] ins;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; instr[d] = 32'h0; ivalid[d] = 1'b0; azero[d] = 1'b0; dack[d] = 1'b0;
            m_ill[d] = 1'b0;
        end
        do_reset(0);
        do_reset(1);

        run_txn(0, 32'h08611400, 0, 1'b0);
        run_txn(0, 32'hFC800040, 3, 1'b0);
        run_txn(0, 32'hEC011000, 0, 1'b1);
        run_txn(0, 32'hEC011000, 0, 1'b0);
        run_txn(0, 32'hE4000000, 0, 1'b0);
        run_txn(0, 32'hE8000000, 0, 1'b0);
        run_txn(0, 32'h80A30000, 1, 1'b0);
        run_txn(0, 32'hF0000000, 0, 1'b0);
        run_txn(0, 32'h08611400, 0, 1'b0);
        run_txn(1, 32'hFC800040, 3, 1'b0);
        run_txn(1, 32'hF0000000, 0, 1'b0);
        run_txn(1, 32'hF0000000, 0, 1'b1);
        run_txn(1, 32'h80A30000, 0, 1'b0);
        run_txn(1, 32'hFC800040, 4, 1'b0);

        // Reset in the middle of a LOAD's memory phase.
        do_reset(1);
        @(negedge clk);
        instr[1] = 32'hFC800040; ivalid[1] = 1'b1;
        @(negedge clk);
        ivalid[1] = 1'b0;
        @(negedge clk);
        chk("midmem_rd", rd[1], 1);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        m_ill[1] = 1'b0;
        chk("midmem_rst_outs", all_outs(1), 32'h0);
        chk("midmem_rst_ready", iready[1], 1);
        for (int i = 0; i < 3; i++) begin
            dack[1] = 1'b1;
            @(negedge clk);
            chk("midmem_no_we", rwe[1], 0);
            chk("midmem_no_pc", pcen[1], 0);
        end
        dack[1] = 1'b0;

        for (int n = 0; n < 300; n++) begin
            int d;
            d = n % 2;
            if (n % 60 == 59) do_reset(d);
            rand_instr(ins);
            run_txn(d, ins, $urandom_range(0, timeout_of(d) + 2), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter DMEM_AW, default 16, meaning data-memory address width (1..16); address is the low DMEM_AW bits of instr[17:2].
REQ-002 Parameter MEM_TIMEOUT, default 15, meaning max cycles waiting for dmem_ack (1..255).
REQ-003 Parameter BNZ_EN, default 0, meaning 1 enables branch-if-not-zero opcode 5'b11100.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 instr / instr_valid / instr_ready  in 32 / in 1 / out 1  instruction fetch handshake; transfer when valid&ready.
REQ-007 alu_zero  in  1  ALU zero flag; dmem_ack  in  1  data-memory completion.
REQ-008 reg_radd0, reg_radd1, reg_wadd  out  5  register-file addresses; reg_file_write_en  out  1; reg_wsel  out  1 (0=ALU, 1=memory).
REQ-009 alu_opcode  out  5; alu_cin  out  1; alu_en  out  1.
REQ-010 data_mem_add  out  DMEM_AW; data_mem_read_en, data_mem_write_en  out  1.
REQ-011 pc_control  out  3; pc_en  out  1 (PC update strobe); illegal  out  1 (sticky); busy  out  1.

Function
REQ-012 States: FETCH, DECODE, EXEC, MEM, RETIRE; all outputs registered.
REQ-013 FETCH: instr_ready=1, busy=0; on handshake latch instr, go DECODE; otherwise stay.
REQ-014 Decode classes: instr[31]=0 -> ALU (op=[30:26], wadd=[25:21], radd0=[20:16], radd1=[15:11], cin=[10]); instr[31]=1 with [30:26]=11111 -> LOAD (wadd=[25:21]); 00000 -> STORE (radd0=[20:16]); 11001 -> JUMP1; 11010 -> JUMP2; 11011 -> BZ; 11100 with BNZ_EN=1 -> BNZ; anything else -> ILLEGAL.
REQ-015 DECODE drives register addresses; next: ALU/BZ/BNZ -> EXEC, LOAD/STORE -> MEM, JUMP1/JUMP2/ILLEGAL -> RETIRE.
REQ-016 EXEC: one cycle, alu_en=1; ALU class drives alu_opcode=op, alu_cin=cin; BZ/BNZ drive alu_opcode=ALU_OP_SUB, alu_cin=0, sample alu_zero; next RETIRE.
REQ-017 MEM: LOAD holds data_mem_read_en=1, STORE holds data_mem_write_en=1, with data_mem_add stable, until dmem_ack=1 (enable drops the cycle after ack), then RETIRE.
REQ-018 MEM timeout: cycle counter counts from entry; if MEM_TIMEOUT cycles elapse without ack, drop enable, set illegal, go RETIRE with no register write.
REQ-019 RETIRE: one cycle, pc_en=1; reg_file_write_en=1 only for ALU (reg_wsel=0) or acked LOAD (reg_wsel=1); next FETCH.
REQ-020 pc_control in RETIRE: JUMP1 001, JUMP2 010, BZ with sampled zero=1 011, BNZ with sampled zero=0 100, else 000.
REQ-021 Latency handshake->RETIRE: ALU/BZ/BNZ 3 cycles, JUMP/ILLEGAL 2 cycles, LOAD/STORE 2 + MEM cycles (minimum 3).
REQ-022 ILLEGAL: set illegal, no memory or register write, pc_control=000.
REQ-023 busy=1 in every state except FETCH; instr_ready=0 outside FETCH.
REQ-024 dmem_ack outside MEM is ignored; alu_zero outside EXEC is ignored.

Reset
REQ-025 rst=1 at a clock edge forces FETCH, clears the MEM counter, and drives all outputs to 0 (instr_ready=1 from the first cycle after reset), including mid-MEM or mid-RETIRE, with no completion strobe.
REQ-026 illegal clears only on rst.

Structure
REQ-027 Package cu_pkg holds the state enum, class enum, opcode constants (11111, 00000, 11001, 11010, 11011, 11100), pc_control encodings and ALU_OP_SUB=5'b00001.
REQ-028 One sub-module, instr_decoder (combinational, instr -> class plus fields); the FSM lives in the top level.

Verification
REQ-029 ALU instr 0x08611400 -> DECODE radd0=1, radd1=2, wadd=3; EXEC alu_opcode=00010, alu_cin=1; RETIRE reg_file_write_en=1, reg_wsel=0, pc_control=000, 3 cycles after handshake.
REQ-030 LOAD 0xFC800040, dmem_ack on the 3rd MEM cycle -> data_mem_add=0x0010, read_en high for 3 cycles; RETIRE wadd=4, write_en=1, reg_wsel=1.
REQ-031 BZ 0xEC011000 with alu_zero=1 in EXEC -> pc_control=011, pc_en=1; repeat with alu_zero=0 -> 000.
REQ-032 STORE with no dmem_ack, MEM_TIMEOUT=4 -> write_en high for 4 cycles; then illegal=1, no register write, back to FETCH.
REQ-033 rst asserted during MEM of a LOAD -> next cycle all enables 0, state FETCH, no reg_file_write_en pulse.
REQ-034 BNZ_EN=0, instr 0xF0000000 -> illegal=1, pc_control=000, pc_en pulse, no writes; BNZ_EN=1, same instr, alu_zero=0 -> pc_control=100.
